fifo_word_packer: RTL and testbench
===================================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter: WIDTH, default 8, byte width of the FIFO read data.
REQ-002 Parameter: LANES, default 4, bytes packed per output word; legal range 2..8.
REQ-003 rd_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rd_reset_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_out  input  WIDTH  read data from the upstream FIFO.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-008 flush  input  1  single-cycle request to emit a partial word.
REQ-009 word_out  output  WIDTH*LANES  packed word.
REQ-010 word_bytes  output  $clog2(LANES+1)  count of valid bytes in word_out.
REQ-011 word_valid  output  1  word_out and word_bytes are valid.
REQ-012 word_ready  input  1  downstream accepts the word when high with word_valid.

Function
REQ-013 The FIFO read latency is fixed: fifo_out carries the byte on the cycle after fifo_rd_en is high with fifo_empty low, and the block captures it on that cycle's rising edge.
REQ-014 States are FILL and HOLD only.
REQ-015 Internal counters are cnt (bytes captured, 0..LANES) and pend (reads in flight, 0..1).
REQ-016 fifo_rd_en is combinational: it is high only when all of the following hold:
- state is FILL
- fifo_empty is low
- cnt+pend < LANES
- no flush is latched
REQ-017 Byte ordering is little-endian: byte k lands in word_out[k*WIDTH +: WIDTH].
REQ-018 On each capture, cnt increments and pend clears in the same cycle.
REQ-019 When a read is issued and a capture occurs in the same cycle, pend stays 1.
REQ-020 FILL -> HOLD when cnt reaches LANES, on the capture edge: word_valid=1, word_bytes=LANES.
REQ-021 A flush in FILL with cnt>0 or pend=1 is latched.
- Once pend=0, the state moves to HOLD with word_bytes=cnt.
- Unused upper lanes of word_out are zero.
REQ-022 A flush in FILL with cnt=0 and pend=0 is ignored.
REQ-023 A flush in HOLD is ignored and is not latched.
REQ-024 In HOLD:
- word_out, word_bytes and word_valid are held stable.
- fifo_rd_en is low.
REQ-025 HOLD -> FILL on the edge where word_valid and word_ready are both high. On that edge:
- cnt clears to 0
- word_out clears to 0
- word_valid clears to 0
- the flush latch clears
REQ-026 There is no throughput requirement beyond one word per LANES+2 cycles at a continuously non-empty FIFO.
REQ-027 A byte is never dropped or duplicated.
REQ-028 fifo_empty rising while pend=1 does not affect the in-flight capture.
REQ-029 word_ready high while word_valid is low has no effect.

Reset
REQ-030 Assertion of rd_reset_n low immediately forces:
- state to FILL
- cnt, pend and the flush latch to 0
- word_out to 0, word_bytes to 0 and word_valid to 0
REQ-031 fifo_rd_en is low while rd_reset_n is low.
REQ-032 Reset asserted mid-word discards the partial word and any in-flight byte.
REQ-033 After reset deasserts, reading restarts no earlier than the first rising edge of rd_clk.

Verification
REQ-034 Full word: FIFO holds 0x11,0x22,0x33,0x44 and word_ready=1 -> word_out=0x44332211, word_bytes=4, one-cycle word_valid, exactly four fifo_rd_en pulses.
REQ-035 Backpressure: word_ready=0 for 10 cycles after word_valid with more data queued -> word_out is held stable, fifo_rd_en stays low, and the next word starts only after the handshake.
REQ-036 Partial flush: bytes 0xA5,0x5A followed by flush -> word_out=0x00005AA5, word_bytes=2.
REQ-037 Flush with a read in flight: flush is asserted on the cycle after the second fifo_rd_en -> word_bytes=2 after capture, and no third read is issued.
REQ-038 Empty stalls: fifo_empty toggles every 3 cycles over 16 random bytes -> 4 words in arrival order, with no loss or duplication, checked by a scoreboard.
REQ-039 Reset mid-word: rd_reset_n pulsed low after 2 bytes captured -> all outputs are 0 immediately, and the next word contains only post-reset bytes.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Packs bytes read from a fixed-latency FIFO into little-endian LANES-byte words.
// A flush request emits the partial word once any in-flight byte has landed.
module fifo_word_packer #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                         rd_clk,
    input  logic                         rd_reset_n,
    input  logic [WIDTH-1:0]             fifo_out,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic                         flush,
    output logic [WIDTH*LANES-1:0]       word_out,
    output logic [$clog2(LANES+1)-1:0]   word_bytes,
    output logic                         word_valid,
    input  logic                         word_ready
);

    localparam int CW = $clog2(LANES + 1);
    localparam logic [CW-1:0] LANES_C = LANES[CW-1:0];

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic                     flush_q, flush_d;
    logic [WIDTH*LANES-1:0]   word_q, word_d;
    logic [CW-1:0]            bytes_q, bytes_d;
    logic                     valid_q, valid_d;

    logic                     fill_s;
    logic                     flush_take_s;
    logic                     flush_pend_s;
    logic                     room_s;

    // Read strobe: also held off by a flush arriving this cycle so no extra byte is fetched.
    always_comb begin
        fill_s       = (state_q == FILL);
        flush_take_s = fill_s && flush && ((cnt_q != {CW{1'b0}}) || pend_q);
        flush_pend_s = flush_q || flush_take_s;
        room_s       = (({1'b0, cnt_q} + {{CW{1'b0}}, pend_q}) < {1'b0, LANES_C});
        fifo_rd_en   = rd_reset_n && fill_s && !fifo_empty && room_s && !flush_pend_s;
    end

    // Next-state: capture the byte requested last cycle, then decide whether the word is done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        flush_d = flush_q;
        word_d  = word_q;
        bytes_d = bytes_q;
        valid_d = valid_q;
        case (state_q)
            FILL: begin
                pend_d  = fifo_rd_en;
                flush_d = flush_pend_s;
                if (pend_q) begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    for (int k = 0; k < LANES; k++) begin
                        if (cnt_q == CW'(k)) begin
                            word_d[k*WIDTH +: WIDTH] = fifo_out;
                        end else begin
                            word_d[k*WIDTH +: WIDTH] = word_q[k*WIDTH +: WIDTH];
                        end
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                if (cnt_d == LANES_C) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    bytes_d = cnt_d;
                end else if (flush_pend_s && !pend_d) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    bytes_d = cnt_d;
                end else begin
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (valid_q && word_ready) begin
                    state_d = FILL;
                    cnt_d   = {CW{1'b0}};
                    pend_d  = 1'b0;
                    flush_d = 1'b0;
                    word_d  = {(WIDTH*LANES){1'b0}};
                    bytes_d = {CW{1'b0}};
                    valid_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = {CW{1'b0}};
                pend_d  = 1'b0;
                flush_d = 1'b0;
                word_d  = {(WIDTH*LANES){1'b0}};
                bytes_d = {CW{1'b0}};
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            state_q <= FILL;
            cnt_q   <= {CW{1'b0}};
            pend_q  <= 1'b0;
            flush_q <= 1'b0;
            word_q  <= {(WIDTH*LANES){1'b0}};
            bytes_q <= {CW{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            word_q  <= word_d;
            bytes_q <= bytes_d;
            valid_q <= valid_d;
        end
    end

    assign word_out   = word_q;
    assign word_bytes = bytes_q;
    assign word_valid = valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: a queue-backed FIFO model feeds bytes,
// expected words are queued as stimulus is built and compared on each handshake.
module tb_fifo_word_packer;

    typedef struct packed {
        logic [31:0] w;
        logic [2:0]  b;
    } exp_t;

    logic        rd_clk;
    logic        rd_reset_n;
    logic [7:0]  fifo_out;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        flush;
    logic [31:0] word_out;
    logic [2:0]  word_bytes;
    logic        word_valid;
    logic        word_ready;

    logic [7:0]  src_q[$];
    exp_t        exp_q[$];

    int n_assert    = 0;
    int n_fail      = 0;
    int words_seen  = 0;
    int rd_pulses   = 0;
    int valid_cycles = 0;

    logic        s_rd;
    logic        s_valid;
    logic [31:0] s_word;

    fifo_word_packer #(.WIDTH(8), .LANES(4)) dut (
        .rd_clk     (rd_clk),
        .rd_reset_n (rd_reset_n),
        .fifo_out   (fifo_out),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .word_out   (word_out),
        .word_bytes (word_bytes),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [2:0] nb);
        exp_t e;
        e.w = {b3, b2, b1, b0};
        e.b = nb;
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs at negedge, sample outputs, model FIFO read latency after posedge.
    task automatic cycle(input logic stall, input logic fl, input logic rdy);
        exp_t e;
        @(negedge rd_clk);
        fifo_empty = stall || (src_q.size() == 0);
        flush      = fl;
        word_ready = rdy;
        #1;
        s_rd    = fifo_rd_en;
        s_valid = word_valid;
        s_word  = word_out;
        if (s_rd) rd_pulses++;
        if (s_valid) valid_cycles++;
        if (word_valid && word_ready) begin
            words_seen++;
            chk("sb_word_expected", {63'd0, (exp_q.size() != 0)}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("word_out", {32'd0, word_out}, {32'd0, e.w});
                chk("word_bytes", {61'd0, word_bytes}, {61'd0, e.b});
            end
        end
        @(posedge rd_clk);
        #1;
        if (s_rd && !fifo_empty) fifo_out = src_q.pop_front();
    endtask

    task automatic drain(input int n, input int budget, input string tag);
        int target = words_seen + n;
        int k = 0;
        while (words_seen < target && k < budget) begin
            cycle(1'b0, 1'b0, 1'b1);
            k++;
        end
        chk({tag, "_timeout"}, {63'd0, (words_seen >= target)}, 64'd1);
    endtask

    initial begin
        int rd0;
        int v0;
        int i;
        int target;
        logic [7:0] rb [4];

        rd_reset_n = 1'b0;
        fifo_empty = 1'b0;
        fifo_out   = 8'h00;
        flush      = 1'b0;
        word_ready = 1'b0;
        s_rd = 1'b0; s_valid = 1'b0; s_word = 32'd0;

        // Reset state, read strobe gated by reset even with a non-empty FIFO
        #12;
        chk("rst_word_out", {32'd0, word_out}, 64'd0);
        chk("rst_word_bytes", {61'd0, word_bytes}, 64'd0);
        chk("rst_word_valid", {63'd0, word_valid}, 64'd0);
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        fifo_empty = 1'b1;
        @(negedge rd_clk);
        rd_reset_n = 1'b1;

        // Full word
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        src_q.push_back(8'h33); src_q.push_back(8'h44);
        push_word(8'h11, 8'h22, 8'h33, 8'h44, 3'd4);
        rd0 = rd_pulses;
        v0  = valid_cycles;
        drain(1, 20, "full");
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
        chk("full_rd_pulses", 64'(rd_pulses - rd0), 64'd4);
        chk("full_valid_cycles", 64'(valid_cycles - v0), 64'd1);

        // Backpressure with a flush during HOLD (must be ignored)
        for (int k = 1; k <= 8; k++) src_q.push_back(8'(k));
        push_word(8'h01, 8'h02, 8'h03, 8'h04, 3'd4);
        push_word(8'h05, 8'h06, 8'h07, 8'h08, 3'd4);
        i = 0;
        s_valid = 1'b0;
        while (!s_valid && i < 20) begin
            cycle(1'b0, 1'b0, 1'b0);
            i++;
        end
        chk("bp_valid_seen", {63'd0, s_valid}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, (k == 4), 1'b0);
            chk("bp_rd_en", {63'd0, s_rd}, 64'd0);
            chk("bp_word_held", {32'd0, s_word}, 64'h04030201);
            chk("bp_valid_held", {63'd0, s_valid}, 64'd1);
        end
        drain(2, 40, "bp");

        // Partial flush
        src_q.push_back(8'hA5); src_q.push_back(8'h5A);
        push_word(8'hA5, 8'h5A, 8'h00, 8'h00, 3'd2);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        drain(1, 10, "pflush");

        // Flush with nothing captured or in flight is ignored
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("empty_flush_ignored", {63'd0, s_valid}, 64'd0);

        // Flush arriving while the second byte is in flight
        src_q.push_back(8'hB1); src_q.push_back(8'hB2); src_q.push_back(8'hB3);
        push_word(8'hB1, 8'hB2, 8'h00, 8'h00, 3'd2);
        push_word(8'hB3, 8'h00, 8'h00, 8'h00, 3'd1);
        rd0 = rd_pulses;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("inflight_no_third_rd", 64'(rd_pulses - rd0), 64'd2);
        cycle(1'b0, 1'b0, 1'b1);
        chk("inflight_rd_after_hs", 64'(rd_pulses - rd0), 64'd2);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        drain(1, 10, "inflight_single");

        // Empty stalls: 16 random bytes, FIFO empty toggling every 3 cycles
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                rb[k] = 8'($urandom_range(0, 255));
                src_q.push_back(rb[k]);
            end
            push_word(rb[0], rb[1], rb[2], rb[3], 3'd4);
        end
        target = words_seen + 4;
        i = 0;
        while (words_seen < target && i < 300) begin
            cycle(((i / 3) % 2) == 1, 1'b0, 1'b1);
            i++;
        end
        chk("stall_words", 64'(words_seen - (target - 4)), 64'd4);

        // Reset mid-word: two bytes captured, third in flight
        for (int k = 1; k <= 7; k++) src_q.push_back(8'(8'hC0 + k));
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
        #2;
        rd_reset_n = 1'b0;
        fifo_empty = 1'b1;
        #1;
        chk("midrst_word_out", {32'd0, word_out}, 64'd0);
        chk("midrst_word_bytes", {61'd0, word_bytes}, 64'd0);
        chk("midrst_word_valid", {63'd0, word_valid}, 64'd0);
        chk("midrst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        @(negedge rd_clk);
        @(posedge rd_clk);
        #1;
        chk("midrst_word_out_held", {32'd0, word_out}, 64'd0);
        @(negedge rd_clk);
        rd_reset_n = 1'b1;
        push_word(8'hC4, 8'hC5, 8'hC6, 8'hC7, 3'd4);
        drain(1, 20, "postrst");

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("src_drained", 64'(src_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
